// File: rtl/register_access_ctrl.sv
// Arbitrates register-board access between the core and a debug port, and
// clears r1..r15 after reset. The core always wins; debug steals single idle cycles.
module register_access_ctrl (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [1:0]  core_a_mode,
    input  logic [3:0]  core_a_sel,
    input  logic [3:0]  core_b_sel,
    input  logic [3:0]  core_d_sel,
    input  logic        core_n_load,
    input  logic        core_n_b_en,
    input  logic        core_idle,
    output logic        core_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [3:0]  dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] dbg_rdata,
    output logic [1:0]  rb_a_mode,
    output logic [3:0]  rb_a_sel,
    output logic [3:0]  rb_b_sel,
    output logic [3:0]  rb_d_sel,
    output logic        rb_n_load,
    output logic        rb_n_b_en,
    output logic [1:0]  rb_d_src,
    output logic [15:0] rb_d_dbg,
    input  logic [15:0] rb_a,
    output logic        init_done
);

    localparam logic [1:0] A_SEL = 2'd0;
    localparam logic [1:0] A_OFF = 2'd3;

    localparam logic [1:0] D_CORE = 2'd0;
    localparam logic [1:0] D_DBG  = 2'd1;
    localparam logic [1:0] D_ZERO = 2'd2;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_DBG_RD,
        S_DBG_WR,
        S_ACK
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  init_cnt;
    logic [3:0]  addr_q;
    logic        accept;

    // A request is only taken when the core has declared the board free.
    assign accept = (state == S_IDLE) && dbg_req && core_idle;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= S_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   if (init_cnt == 4'd15) state_nxt = S_IDLE;
            S_IDLE:   if (accept) state_nxt = dbg_we ? S_DBG_WR : S_DBG_RD;
            S_DBG_RD: state_nxt = S_ACK;
            S_DBG_WR: state_nxt = S_ACK;
            S_ACK:    if (!dbg_req) state_nxt = S_IDLE;
            default:  state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        rb_a_mode  = core_a_mode;
        rb_a_sel   = core_a_sel;
        rb_b_sel   = core_b_sel;
        rb_d_sel   = core_d_sel;
        rb_n_load  = core_n_load;
        rb_n_b_en  = core_n_b_en;
        rb_d_src   = D_CORE;
        core_stall = 1'b0;
        dbg_ack    = 1'b0;
        case (state)
            S_INIT: begin
                rb_a_mode  = A_OFF;
                rb_a_sel   = 4'd0;
                rb_b_sel   = 4'd0;
                rb_d_sel   = init_cnt;
                rb_n_load  = 1'b0;
                rb_n_b_en  = 1'b1;
                rb_d_src   = D_ZERO;
                core_stall = 1'b1;
            end
            S_DBG_RD: begin
                rb_a_mode  = A_SEL;
                rb_a_sel   = addr_q;
                rb_b_sel   = 4'd0;
                rb_d_sel   = 4'd0;
                rb_n_load  = 1'b1;
                rb_n_b_en  = 1'b1;
                core_stall = 1'b1;
            end
            S_DBG_WR: begin
                rb_a_mode  = A_OFF;
                rb_a_sel   = 4'd0;
                rb_b_sel   = 4'd0;
                rb_d_sel   = addr_q;
                rb_n_load  = 1'b0;
                rb_n_b_en  = 1'b1;
                rb_d_src   = D_DBG;
                core_stall = 1'b1;
            end
            S_ACK:   dbg_ack = 1'b1;
            default: ;
        endcase
    end

    // Sweep counter, debug latches and read-data capture.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            init_cnt  <= 4'd1;
            init_done <= 1'b0;
            addr_q    <= 4'd0;
            rb_d_dbg  <= 16'h0000;
            dbg_rdata <= 16'h0000;
        end else begin
            if (state == S_INIT) begin
                init_cnt <= init_cnt + 4'd1;
                if (init_cnt == 4'd15) init_done <= 1'b1;
            end
            if (accept) begin
                addr_q   <= dbg_addr;
                rb_d_dbg <= dbg_wdata;
            end
            if (state == S_DBG_RD) dbg_rdata <= rb_a;
        end
    end

endmodule

// File: doc/register_access_ctrl.md
REGISTER_ACCESS_CTRL -- requirements
Module: register_access_ctrl

Interface
REQ-001: clk  input  1  system clock; all state changes on rising edge.
REQ-002: n_reset  input  1  reset, asynchronous and active-low.
REQ-003: core_a_mode, core_a_sel, core_b_sel, core_d_sel  input  2/4/4/4  core register-board controls: A mode, A select, B select, destination select.
REQ-004: core_n_load, core_n_b_en  input  1/1  core write strobe and B enable, active-low.
REQ-005: core_idle  input  1  core is not using the register board this cycle.
REQ-006: core_stall  output  1  core must hold its current micro-step.
REQ-007: dbg_req, dbg_we  input  1/1  debug request; write (1) or read (0).
REQ-008: dbg_addr, dbg_wdata  input  4/16  debug register index and write data.
REQ-009: dbg_ack, dbg_rdata  output  1/16  debug acknowledge and read data.
REQ-010: rb_a_mode, rb_a_sel, rb_b_sel, rb_d_sel  output  2/4/4/4  register-board controls; A mode encoding 0=A_SEL, 1=D_SEL, 2=A_ZERO, 3=A_OFF.
REQ-011: rb_n_load, rb_n_b_en  output  1/1  register-board write strobe and B enable, active-low.
REQ-012: rb_d_src, rb_d_dbg  output  2/16  D-bus source select (0=core, 1=rb_d_dbg, 2=zero) and latched debug write data.
REQ-013: rb_a  input  16  register-board A output, sampled for debug reads.
REQ-014: init_done  output  1  register clear sweep complete.

Function
REQ-015: The block SHALL implement states INIT, IDLE, DBG_RD, DBG_WR, ACK.
REQ-016: INIT SHALL hold a 4-bit counter that starts at 1; each cycle it SHALL drive rb_n_load=0, rb_d_sel=counter, rb_d_src=2, rb_a_mode=3, rb_n_b_en=1, core_stall=1, and the counter SHALL increment.
REQ-017: INIT SHALL last exactly 15 cycles, writing r1..r15 in order; after the counter=15 cycle the block SHALL enter IDLE and init_done SHALL become 1 and stay 1 until reset.
REQ-018: In IDLE, rb_* controls SHALL equal the core_* inputs combinationally, with rb_d_src=0 and core_stall=0.
REQ-019: In IDLE, with dbg_req=1 and core_idle=1 at a rising edge, the block SHALL latch dbg_addr and dbg_wdata and enter DBG_WR if dbg_we=1, or DBG_RD otherwise.
REQ-020: dbg_req=1 with core_idle=0 SHALL leave the block in IDLE, so the core always has priority.
REQ-021: DBG_RD SHALL drive rb_a_mode=0, rb_a_sel=latched addr, rb_n_load=1, rb_n_b_en=1, core_stall=1; at the next edge it SHALL capture rb_a into dbg_rdata and enter ACK.
REQ-022: DBG_WR SHALL drive rb_n_load=0, rb_d_sel=latched addr, rb_d_src=1, rb_a_mode=3, rb_n_b_en=1, core_stall=1, then enter ACK.
REQ-023: A debug write to address 0 SHALL still complete and be acknowledged; r0 keeps its value because the board ignores writes to r0.
REQ-024: ACK SHALL drive dbg_ack=1, pass the core controls through as in IDLE, and keep core_stall=0.
REQ-025: ACK SHALL stay until dbg_req=0 is sampled, then return to IDLE (4-phase handshake); dbg_ack SHALL be 0 in every other state.
REQ-026: Debug latency SHALL be exactly 2 cycles from the accepting edge to dbg_ack=1, and core_stall SHALL be 1 for exactly 1 cycle.
REQ-027: A core_idle drop during DBG_RD or DBG_WR SHALL be ignored and the operation SHALL complete.
REQ-028: dbg_req asserted during INIT SHALL be held off until IDLE.
REQ-029: dbg_rdata SHALL hold its last captured value until the next debug read.
REQ-030: rb_d_dbg SHALL hold the latched write data until the next accepted debug request.

Reset
REQ-031: n_reset=0 SHALL force, immediately: state INIT, counter 1, init_done=0, dbg_ack=0, dbg_rdata=0, rb_d_dbg=0, core_stall=1.
REQ-032: Reset asserted mid-operation SHALL abort the operation with no ack and restart the INIT sweep.

Verification
REQ-033: Release reset -> rb_n_load=0 with rb_d_sel=1..15 on 15 consecutive cycles, rb_d_src=2, then init_done=1; every register reads 0x0000.
REQ-034: Debug write addr=5, data=0xBEEF with core_idle=1 -> one DBG_WR cycle, dbg_ack on the 2nd cycle; a following debug read of addr 5 returns 0xBEEF.
REQ-035: dbg_req=1 with core_idle=0 for 10 cycles -> no stall and core controls pass through; core_idle=1 -> request accepted at the next edge.
REQ-036: Debug write addr=0, data=0x1234 -> acked; a debug read of addr 0 returns 0x0000.
REQ-037: Hold dbg_req high 5 cycles after ack -> dbg_ack stays 1 and no second access; drop dbg_req -> IDLE, and a new request is accepted.
REQ-038: Assert n_reset during DBG_RD -> dbg_ack=0 and dbg_rdata=0 at once; after release, a full 15-cycle INIT sweep runs.
